// File: rtl/ines_loader.sv
// ines_loader: streams an iNES image in byte by byte, checks the header,
// skips an optional trainer, writes the PRG and CHR payloads into the cartridge
// memories and publishes the static cartridge configuration for the mapper.
// The cartridge stays in reset until the whole image has been loaded.
module ines_loader #(
    parameter int PRG_ROM_DEPTH = 17,
    parameter int CHR_ROM_DEPTH = 15,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic [7:0]               wr_data,
    output logic                     prg_we,
    output logic [PRG_ROM_DEPTH-1:0] prg_wr_addr,
    output logic                     chr_we,
    output logic [CHR_ROM_DEPTH-1:0] chr_wr_addr,
    output logic [7:0]               mapper_id,
    output logic                     mirrorv,
    output logic                     prg_ram,
    output logic                     chr_ram,
    output logic [PRG_ROM_DEPTH-1:0] prg_mask,
    output logic [CHR_ROM_DEPTH-1:0] chr_mask,
    output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic                     cart_rst,
    output logic                     done,
    output logic                     error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_TRAINER = 3'd2;
    localparam logic [2:0] S_PRG     = 3'd3;
    localparam logic [2:0] S_CHR     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    // Largest payload sizes the ROM address spaces can hold.
    localparam logic [31:0] PRG_CAP = 32'd1 << PRG_ROM_DEPTH;
    localparam logic [31:0] CHR_CAP = 32'd1 << CHR_ROM_DEPTH;

    logic [2:0]  state;
    logic [3:0]  hdr_cnt;
    logic [8:0]  trn_cnt;
    logic [21:0] pay_cnt;

    // Header fields captured while the header streams past.
    logic [7:0]  hdr_prg16;
    logic [7:0]  hdr_chr8;
    logic [3:0]  hdr_map_lo;
    logic [3:0]  hdr_map_hi;
    logic        hdr_mirror;
    logic        hdr_prgram;
    logic        hdr_trainer;

    logic        accept;
    logic [7:0]  hdr_mapper;
    logic [21:0] prg_bytes;
    logic [21:0] chr_bytes;
    logic        mapper_ok;
    logic        hdr_bad;
    logic        prg_last;
    logic        chr_last;

    // Expected magic "NES\x1A" for header bytes 0..3.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h4E;
            2'd1:    return 8'h45;
            2'd2:    return 8'h53;
            default: return 8'h1A;
        endcase
    endfunction

    // Smallest power of two that is >= n (n == 0 yields 1).
    function automatic logic [8:0] next_pow2(input logic [7:0] n);
        logic [8:0] p;
        p = 9'd1;
        for (int i = 0; i < 8; i++) begin
            if ({1'b0, n} > p) begin
                p = p << 1;
            end
        end
        return p;
    endfunction

    assign accept      = in_valid && in_ready;
    assign in_ready    = (state == S_HDR) || (state == S_TRAINER) ||
                         (state == S_PRG) || (state == S_CHR);
    assign cart_rst    = (state != S_DONE);
    assign error       = (state == S_ERROR);
    assign prgram_mask = '1;

    assign hdr_mapper = {hdr_map_hi, hdr_map_lo};
    assign prg_bytes  = {hdr_prg16, 14'd0};
    assign chr_bytes  = {1'b0, hdr_chr8, 13'd0};
    assign mapper_ok  = (hdr_mapper == 8'd0) || (hdr_mapper == 8'd2) ||
                        (hdr_mapper == 8'd3) || (hdr_mapper == 8'd7);
    assign hdr_bad    = !mapper_ok || (hdr_prg16 == 8'd0) ||
                        ({10'd0, prg_bytes} > PRG_CAP) ||
                        ({10'd0, chr_bytes} > CHR_CAP);
    assign prg_last   = (pay_cnt == (prg_bytes - 22'd1));
    assign chr_last   = (pay_cnt == (chr_bytes - 22'd1));

    // Load sequencer: header parse, trainer skip, PRG then CHR payload counting.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state       <= S_IDLE;
            hdr_cnt     <= '0;
            trn_cnt     <= '0;
            pay_cnt     <= '0;
            hdr_prg16   <= '0;
            hdr_chr8    <= '0;
            hdr_map_lo  <= '0;
            hdr_map_hi  <= '0;
            hdr_mirror  <= 1'b0;
            hdr_prgram  <= 1'b0;
            hdr_trainer <= 1'b0;
        end else if (start) begin
            state   <= S_HDR;
            hdr_cnt <= '0;
            trn_cnt <= '0;
            pay_cnt <= '0;
        end else begin
            case (state)
                S_HDR: begin
                    if (accept) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        if ((hdr_cnt <= 4'd3) && (in_data != magic_byte(hdr_cnt[1:0]))) begin
                            state <= S_ERROR;
                        end
                        case (hdr_cnt)
                            4'd4: hdr_prg16 <= in_data;
                            4'd5: hdr_chr8  <= in_data;
                            4'd6: begin
                                hdr_map_lo  <= in_data[7:4];
                                hdr_trainer <= in_data[2];
                                hdr_prgram  <= in_data[1];
                                hdr_mirror  <= in_data[0];
                            end
                            4'd7: hdr_map_hi <= in_data[7:4];
                            4'd15: begin
                                if (hdr_bad) begin
                                    state <= S_ERROR;
                                end else if (hdr_trainer) begin
                                    state <= S_TRAINER;
                                end else begin
                                    state <= S_PRG;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_TRAINER: begin
                    if (accept) begin
                        trn_cnt <= trn_cnt + 9'd1;
                        if (trn_cnt == 9'd511) begin
                            state <= S_PRG;
                        end
                    end
                end
                S_PRG: begin
                    if (accept) begin
                        if (prg_last) begin
                            pay_cnt <= '0;
                            state   <= (hdr_chr8 == 8'd0) ? S_DONE : S_CHR;
                        end else begin
                            pay_cnt <= pay_cnt + 22'd1;
                        end
                    end
                end
                S_CHR: begin
                    if (accept) begin
                        if (chr_last) begin
                            state <= S_DONE;
                        end else begin
                            pay_cnt <= pay_cnt + 22'd1;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERROR: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Cartridge configuration latched as the final header byte is taken.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            mapper_id <= '0;
            mirrorv   <= 1'b0;
            prg_ram   <= 1'b0;
            chr_ram   <= 1'b0;
            prg_mask  <= '0;
            chr_mask  <= '0;
        end else if (!start && (state == S_HDR) && accept && (hdr_cnt == 4'd15)) begin
            mapper_id <= hdr_mapper;
            mirrorv   <= hdr_mirror;
            prg_ram   <= hdr_prgram;
            chr_ram   <= (hdr_chr8 == 8'd0);
            prg_mask  <= PRG_ROM_DEPTH'({next_pow2(hdr_prg16), 14'd0} - 23'd1);
            chr_mask  <= CHR_ROM_DEPTH'({next_pow2(hdr_chr8), 13'd0} - 22'd1);
        end
    end

    // Memory write port: one registered strobe per accepted payload byte.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            prg_we      <= 1'b0;
            chr_we      <= 1'b0;
            wr_data     <= '0;
            prg_wr_addr <= '0;
            chr_wr_addr <= '0;
        end else begin
            prg_we <= !start && accept && (state == S_PRG);
            chr_we <= !start && accept && (state == S_CHR);
            if (!start && accept && (state == S_PRG)) begin
                wr_data     <= in_data;
                prg_wr_addr <= pay_cnt[PRG_ROM_DEPTH-1:0];
            end
            if (!start && accept && (state == S_CHR)) begin
                wr_data     <= in_data;
                chr_wr_addr <= pay_cnt[CHR_ROM_DEPTH-1:0];
            end
        end
    end

    // done trails the DONE state by a cycle and drops as soon as a restart begins.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_DONE) && !start;
        end
    end

endmodule
